// File: rtl/apb_gpio_spi_ctrl_pkg.sv
// apb_gpio_spi_ctrl_pkg: register offsets, default read value and pad indices
package apb_gpio_spi_ctrl_pkg;
  localparam logic [7:0] GPIO_OUT = 8'h40;
  localparam logic [7:0] GPIO_DIR = 8'h44;
  localparam logic [7:0] GPIO_PIN = 8'h48;
  localparam logic [7:0] SPI_DATA = 8'h4C;
  localparam logic [7:0] SPI_CNT  = 8'h50;
  localparam logic [7:0] SPI_STA  = 8'h54;
  localparam logic [7:0] CURSOR_X = 8'h80;
  localparam logic [7:0] CURSOR_Y = 8'h84;
  localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;
  localparam int MISO = 0;
  localparam int MOSI = 1;
  localparam int SCK  = 2;
  localparam int CS   = 3;
endpackage

// File: rtl/apb_gpio_spi_ctrl_spi_shifter.sv
// apb_gpio_spi_ctrl_spi_shifter: two-phase MSB-first bit-serial SPI stepper
module apb_gpio_spi_ctrl_spi_shifter
  import apb_gpio_spi_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        cpu_reset_n,
  input  logic        start,
  input  logic        stall,
  input  logic [7:0]  cnt_wdata,
  input  logic [31:0] spi_out,
  input  logic        miso,
  output logic [7:0]  spi_cnt,
  output logic [7:0]  spi_sta,
  output logic [31:0] spi_in,
  output logic        mosi_en,
  output logic        mosi,
  output logic        sck_en,
  output logic        sck
);
  logic [4:0] next_bit;
  logic [4:0] first_bit;
  logic       step;
  assign first_bit = cnt_wdata[4:0] - 5'd1;
  assign step      = !stall && spi_cnt != 8'd0;
  assign mosi_en   = start || (step && spi_sta != 8'd0);
  assign mosi      = spi_out[start ? first_bit : next_bit];
  assign sck_en    = start || step;
  assign sck       = step && spi_sta == 8'd0;
  // start loads the transfer; otherwise alternate sample/rise and shift/fall phases
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      spi_cnt  <= '0;
      spi_sta  <= '0;
      spi_in   <= '0;
      next_bit <= '0;
    end else if (start) begin
      spi_in   <= '0;
      spi_sta  <= '0;
      spi_cnt  <= cnt_wdata;
      next_bit <= first_bit;
    end else if (step) begin
      if (spi_sta == 8'd0) begin
        spi_in[next_bit] <= miso;
        next_bit         <= next_bit - 5'd1;
        spi_sta          <= 8'd3;
      end else begin
        spi_sta <= '0;
        spi_cnt <= spi_cnt - 8'd1;
      end
    end
  end
endmodule

// File: rtl/apb_gpio_spi_ctrl.sv
// apb_gpio_spi_ctrl: APB3 slave with SD-pad GPIO, SPI shifter and LCD cursor registers
module apb_gpio_spi_ctrl
  import apb_gpio_spi_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              cpu_reset_n,
  input  logic [ADDR_W-1:0] apb_paddr,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic              apb_pready,
  input  logic [5:0]        pad_i,
  output logic [5:0]        pad_o,
  output logic [5:0]        pad_oe,
  output logic [31:0]       cursor_x,
  output logic [31:0]       cursor_y
);
  logic [7:0]  addr;
  logic        wr, rd, wr_last, wr_en;
  logic [7:0]  gpio_out, gpio_dir;
  logic [5:0]  pin;
  logic [31:0] spi_out, spi_in;
  logic [7:0]  spi_cnt, spi_sta;
  logic        mosi_en, mosi, sck_en, sck;
  assign addr       = apb_paddr[7:0];
  assign wr         = apb_psel && apb_penable && apb_pwrite;
  assign rd         = apb_psel && apb_penable && !apb_pwrite;
  assign wr_en      = wr && !wr_last;
  assign apb_pready = 1'b1;
  assign pad_o      = gpio_out[5:0];
  assign pad_oe     = gpio_dir[5:0];
  apb_gpio_spi_ctrl_spi_shifter u_spi (
    .clk        (clk),
    .cpu_reset_n(cpu_reset_n),
    .start      (wr_en && addr == SPI_CNT),
    .stall      (wr_en),
    .cnt_wdata  (apb_pwdata[7:0]),
    .spi_out    (spi_out),
    .miso       (pad_i[MISO]),
    .spi_cnt    (spi_cnt),
    .spi_sta    (spi_sta),
    .spi_in     (spi_in),
    .mosi_en    (mosi_en),
    .mosi       (mosi),
    .sck_en     (sck_en),
    .sck        (sck)
  );
  // plain storage registers, pin sampling and write-edge tracking
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_last  <= 1'b0;
      pin      <= '0;
      gpio_dir <= '0;
      spi_out  <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      wr_last <= wr;
      pin     <= pad_i;
      if (wr_en && addr == GPIO_DIR) gpio_dir <= apb_pwdata[7:0];
      if (wr_en && addr == SPI_DATA) spi_out  <= apb_pwdata;
      if (wr_en && addr == CURSOR_X) cursor_x <= apb_pwdata;
      if (wr_en && addr == CURSOR_Y) cursor_y <= apb_pwdata;
    end
  end
  // gpio_out takes CPU writes; the shifter owns MOSI/SCK in the cycles it acts
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      gpio_out <= '0;
    end else if (wr_en && addr == GPIO_OUT) begin
      gpio_out <= apb_pwdata[7:0];
    end else begin
      if (mosi_en) gpio_out[MOSI] <= mosi;
      if (sck_en) gpio_out[SCK] <= sck;
    end
  end
  // combinational read mux; all-ones when idle or unmapped
  always_comb begin
    apb_prdata = RD_DEFAULT;
    if (rd)
      case (addr)
        GPIO_OUT: apb_prdata = {24'd0, gpio_out};
        GPIO_DIR: apb_prdata = {24'd0, gpio_dir};
        GPIO_PIN: apb_prdata = {26'd0, pin};
        SPI_DATA: apb_prdata = spi_in;
        SPI_CNT:  apb_prdata = {24'd0, spi_cnt};
        SPI_STA:  apb_prdata = {24'd0, spi_sta};
        CURSOR_X: apb_prdata = cursor_x;
        CURSOR_Y: apb_prdata = cursor_y;
        default:  apb_prdata = RD_DEFAULT;
      endcase
  end
endmodule

// File: tb/tb_apb_gpio_spi_ctrl.sv
// tb_apb_gpio_spi_ctrl: scoreboard bench for the APB GPIO/SPI/cursor block
module tb_apb_gpio_spi_ctrl;
  logic        clk = 1'b0;
  logic        cpu_reset_n = 1'b0;
  logic [7:0]  apb_paddr = '0;
  logic        apb_psel = 1'b0;
  logic        apb_penable = 1'b0;
  logic        apb_pwrite = 1'b0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic [5:0]  pad_i, pad_o, pad_oe;
  logic [31:0] cursor_x, cursor_y;
  logic [5:0]  pad_drv = '0;
  logic [1:0]  miso_mode = '0;
  logic [31:0] pat = 32'h3C5A_9612;
  logic [4:0]  idx = 5'd31;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] v;
  } exp_t;
  exp_t rd_q[$];
  exp_t pr_q[$];
  logic mosi_q[$];
  int   npass = 0, ntot = 0;
  int   rises = 0, first_cyc = 0, last_cyc = 0, cyc = 0;
  logic probe_req = 1'b0, mon_clr = 1'b0, mon_en = 1'b0, fin = 1'b0, fin_done = 1'b0;
  logic prev_sck = 1'b0;
  always #5 clk = ~clk;
  assign pad_i = {pad_drv[5:1], miso_mode == 2'd1 ? pad_o[1] : miso_mode == 2'd2 ? pat[idx] : pad_drv[0]};
  apb_gpio_spi_ctrl #(.ADDR_W(8)) dut (
    .clk        (clk),
    .cpu_reset_n(cpu_reset_n),
    .apb_paddr  (apb_paddr),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_prdata (apb_prdata),
    .apb_pready (apb_pready),
    .pad_i      (pad_i),
    .pad_o      (pad_o),
    .pad_oe     (pad_oe),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  function automatic logic [31:0] probe_val(input int s);
    return s == 0 ? {20'd0, pad_oe, pad_o} : s == 1 ? cursor_x : s == 2 ? cursor_y :
           s == 3 ? apb_prdata : {rises[15:0], 16'(last_cyc - first_cyc)};
  endfunction
  // monitor: all comparisons happen here, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_clr) begin
      rises = 0;
      idx = 5'd31;
    end
    if (mon_en && pad_o[2] && !prev_sck) begin
      rises++;
      if (rises == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (mosi_q.size() == 0) begin
        ntot++;
        $display("FAIL sck_extra_pulse: got pulse %0d expected none", rises);
      end else chk("mosi_bit", 32'(pad_o[1]), 32'(mosi_q.pop_front()));
    end
    if (mon_en && !pad_o[2] && prev_sck) idx = idx - 5'd1;
    prev_sck = pad_o[2];
    if (apb_psel && apb_penable && !apb_pwrite) begin
      if (rd_q.size() == 0) begin
        ntot++;
        $display("FAIL read_unexpected: got %h expected no read", apb_prdata);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, apb_prdata, e.v);
      end
    end
    if (probe_req && pr_q.size() != 0) begin
      e = pr_q.pop_front();
      chk(e.name, probe_val(e.sel), e.v);
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk("queues_drained", 32'(rd_q.size() + pr_q.size() + mosi_q.size()), 32'd0);
    end
  end
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input int hold = 1);
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = a; apb_pwdata = d; apb_penable = 1'b0;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
  endtask
  task automatic apb_read(input logic [7:0] a, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n; e.sel = 0; e.v = v;
    rd_q.push_back(e);
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_pwrite = 1'b0; apb_paddr = a; apb_penable = 1'b0;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    @(posedge clk); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask
  task automatic probe(input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n; e.sel = s; e.v = v;
    pr_q.push_back(e);
    @(posedge clk); #1;
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask
  task automatic arm(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) mosi_q.push_back(data[i]);
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    mon_en = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 cpu_reset_n = 1'b1;
    probe(0, 32'd0, "pads_after_reset");
    apb_read(8'h40, 32'd0, "rst_gpio_out");
    apb_read(8'h44, 32'd0, "rst_gpio_dir");
    apb_read(8'h50, 32'd0, "rst_spi_cnt");
    apb_read(8'h80, 32'd0, "rst_cursor_x");
    apb_read(8'h10, 32'hFFFF_FFFF, "unmapped_read");
    probe(3, 32'hFFFF_FFFF, "prdata_idle");
    pad_drv = 6'h25;
    apb_write(8'h44, 32'h0F);
    apb_write(8'h40, 32'h0A);
    probe(0, {20'd0, 6'h0F, 6'h0A}, "pads_gpio");
    apb_read(8'h48, 32'h25, "gpio_pin");
    apb_write(8'h4C, 32'hA5);
    apb_write(8'h44, 32'h0E);
    miso_mode = 2'd1;
    arm(32'hA5, 8);
    apb_write(8'h50, 32'd8);
    repeat (20) @(posedge clk);
    #1 mon_en = 1'b0;
    probe(4, {16'd8, 16'd14}, "spi8_pulses_span");
    probe(0, {20'd0, 6'h0E, 6'h08}, "pads_after_spi8");
    apb_read(8'h50, 32'd0, "spi8_cnt_done");
    apb_read(8'h54, 32'd0, "spi8_sta_done");
    apb_read(8'h4C, 32'hA5, "spi8_loopback_in");
    apb_write(8'h4C, 32'h8000_0001);
    miso_mode = 2'd2;
    arm(32'h8000_0001, 32);
    apb_write(8'h50, 32'h20);
    repeat (70) @(posedge clk);
    #1 mon_en = 1'b0;
    probe(4, {16'd32, 16'd62}, "spi32_pulses_span");
    apb_read(8'h4C, 32'h3C5A_9612, "spi32_in");
    apb_read(8'h50, 32'd0, "spi32_cnt_done");
    apb_write(8'h80, 32'h12);
    apb_write(8'h84, 32'h34);
    probe(1, 32'h12, "cursor_x_out");
    probe(2, 32'h34, "cursor_y_out");
    apb_read(8'h80, 32'h12, "cursor_x_rd");
    apb_read(8'h84, 32'h34, "cursor_y_rd");
    miso_mode = 2'd0;
    arm(32'h8000_0001, 2);
    apb_write(8'h50, 32'd2, 5);
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    apb_read(8'h50, 32'd0, "held_write_single_start");
    probe(4, {16'd2, 16'd2}, "held_pulses_span");
    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
